// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC, imem req/ready fetch, one-entry hold buffer, redirects.
// Optional IFU_PERF_COUNTERS_EN adds fetch_count / stall_count outputs.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'hE000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_out,
   output logic [31:0] PC_out,
   output logic        valid_out,
   output logic        flush_out
`ifdef IFU_PERF_COUNTERS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;
   logic        flush_q, flush_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;

   logic        redirect_s;
   logic [31:0] target_s;
   logic [31:0] pc_plus4_s;
   logic        accept_s;
   logic        deliver_s;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect decode and fetch/delivery qualifiers
   always_comb begin
      redirect_s = branch_taken | jump;
      if (branch_taken) begin
         target_s = {branch_target[31:2], 2'b00};
      end else begin
         target_s = {jump_target[31:2], 2'b00};
      end
      pc_plus4_s = pc_q + 32'd4;
      accept_s   = (state_q == S_REQ) && imem_ready && !redirect_s;
      if (redirect_s || enable) begin
         deliver_s = 1'b0;
      end else if (state_q == S_HOLD) begin
         deliver_s = 1'b1;
      end else begin
         deliver_s = accept_s;
      end
   end

   // Next-state logic; a redirect with the request still open must wait out the handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (redirect_s && !imem_ready) begin
               state_d = S_DRAIN;
            end else if (!redirect_s && imem_ready && enable) begin
               state_d = S_HOLD;
            end else begin
               state_d = S_REQ;
            end
         end
         S_HOLD: begin
            if (redirect_s || !enable) begin
               state_d = S_REQ;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_DRAIN: begin
            if (imem_ready) begin
               state_d = S_REQ;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output/datapath next values: PC, fetch port, hold buffer, IF/ID outputs
   always_comb begin
      if (redirect_s) begin
         pc_d = target_s;
      end else if (accept_s) begin
         pc_d = pc_plus4_s;
      end else begin
         pc_d = pc_q;
      end

      // The old address stays on the bus while a discarded request drains
      if (state_d == S_DRAIN) begin
         addr_d = addr_q;
      end else begin
         addr_d = pc_d;
      end
      req_d = (state_d == S_REQ) || (state_d == S_DRAIN);

      if (redirect_s || (deliver_s && (state_q == S_HOLD))) begin
         hold_instr_d = NOP_WORD;
         hold_pc_d    = 32'h0000_0000;
      end else if (accept_s && enable) begin
         hold_instr_d = imem_rdata;
         hold_pc_d    = pc_plus4_s;
      end else begin
         hold_instr_d = hold_instr_q;
         hold_pc_d    = hold_pc_q;
      end

      flush_d = redirect_s;
      if (redirect_s) begin
         instr_d  = NOP_WORD;
         pc_out_d = pc_out_q;
         valid_d  = 1'b0;
      end else if (deliver_s && (state_q == S_HOLD)) begin
         instr_d  = hold_instr_q;
         pc_out_d = hold_pc_q;
         valid_d  = 1'b1;
      end else if (deliver_s) begin
         instr_d  = imem_rdata;
         pc_out_d = pc_plus4_s;
         valid_d  = 1'b1;
      end else if (!enable) begin
         instr_d  = NOP_WORD;
         pc_out_d = pc_out_q;
         valid_d  = 1'b0;
      end else begin
         instr_d  = instr_q;
         pc_out_d = pc_out_q;
         valid_d  = valid_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         instr_q      <= NOP_WORD;
         pc_out_q     <= 32'h0000_0000;
         valid_q      <= 1'b0;
         flush_q      <= 1'b0;
         hold_instr_q <= NOP_WORD;
         hold_pc_q    <= 32'h0000_0000;
      end else begin
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         valid_q      <= valid_d;
         flush_q      <= flush_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   assign imem_req        = req_q;
   assign imem_addr       = addr_q;
   assign Instruction_out = instr_q;
   assign PC_out          = pc_out_q;
   assign valid_out       = valid_q;
   assign flush_out       = flush_q;

`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   // Performance counter next values (free-running, wrap at 2^32)
   always_comb begin
      fetch_count_d = fetch_count_q + {31'd0, deliver_s};
      stall_count_d = stall_count_q + {31'd0, enable};
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count_q <= 32'h0000_0000;
         stall_count_q <= 32'h0000_0000;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, corner sequences,
// and random traffic against a queue-based reference model of the fetch stream.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'hE000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] Instruction_out;
   logic [31:0] PC_out;
   logic        valid_out;
   logic        flush_out;
`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   instruction_fetch_unit dut (
      .clk(clk), .reset(reset), .enable(enable),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .Instruction_out(Instruction_out), .PC_out(PC_out),
      .valid_out(valid_out), .flush_out(flush_out)
`ifdef IFU_PERF_COUNTERS_EN
      , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int deliveries = 0;

   // Memory responder state
   int lat_mode = 1;     // <0: random latency 0..3
   int lat_cnt = 0;
   int lat_target = 1;

   // Reference model: expected fetch PC, one-deep pending queue, stale-request tracking
   logic [31:0] m_pc;
   logic        m_qv;
   logic [31:0] m_qi, m_qp;
   logic        m_stale;
   logic [31:0] m_stale_addr;
   logic [31:0] e_instr, e_pco;
   logic        e_valid, e_flush;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
   endfunction

   function automatic int pick_lat();
      if (lat_mode < 0) return int'($urandom_range(0, 3));
      else return lat_mode;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_instr"}, Instruction_out, NOP);
      chk({tag, "_pcout"}, PC_out, 32'h0);
      chk({tag, "_valid"}, 32'(valid_out), 32'd0);
      chk({tag, "_flush"}, 32'(flush_out), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      enable = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      m_pc = 32'h0; m_qv = 1'b0; m_qi = NOP; m_qp = 32'h0;
      m_stale = 1'b0; m_stale_addr = 32'h0;
      e_instr = NOP; e_pco = 32'h0; e_valid = 1'b0; e_flush = 1'b0;
      lat_cnt = 0; lat_target = pick_lat();
      reset = 1'b1;
   endtask

   // One clock cycle: entered and left at a negedge; memory responds, model advances, outputs compared
   task automatic step(input logic en, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
      logic rdy, redirect, req_s, accepted, real_w;
      logic [31:0] tgt, addr_s;
      enable = en; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
      req_s  = imem_req;
      addr_s = imem_addr;
      rdy = req_s && (lat_cnt >= lat_target);
      imem_ready = rdy;
      imem_rdata = rdy ? mem_word(addr_s) : 32'hDEAD_BEEF;
      redirect = br | jp;
      tgt = br ? bt : jt;
      tgt[1:0] = 2'b00;
      if (req_s) begin
         if (m_stale) chk("drain_addr_stable", addr_s, m_stale_addr);
         else chk("fetch_addr", addr_s, m_pc);
      end
      if (m_qv) chk("hold_no_req", 32'(req_s), 32'd0);
      accepted = req_s && rdy;
      real_w = accepted && !m_stale && !redirect;
      if (accepted) m_stale = 1'b0;
      else if (redirect && req_s) begin
         m_stale = 1'b1;
         m_stale_addr = addr_s;
      end
      if (redirect) begin
         m_pc = tgt; m_qv = 1'b0;
         e_instr = NOP; e_valid = 1'b0; e_flush = 1'b1;
      end else begin
         e_flush = 1'b0;
         if (real_w) begin
            m_qv = 1'b1; m_qi = mem_word(m_pc); m_qp = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
         end
         if (!en) begin
            if (m_qv) begin
               e_instr = m_qi; e_pco = m_qp; e_valid = 1'b1;
               m_qv = 1'b0; deliveries++;
            end else begin
               e_instr = NOP; e_valid = 1'b0;
            end
         end
      end
      @(posedge clk);
      if (accepted) begin
         lat_cnt = 0; lat_target = pick_lat();
      end else if (req_s) lat_cnt++;
      @(negedge clk);
      imem_ready = 1'b0;
      chk("instr", Instruction_out, e_instr);
      chk("pc_out", PC_out, e_pco);
      chk("valid", 32'(valid_out), 32'(e_valid));
      chk("flush", 32'(flush_out), 32'(e_flush));
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (valid_out !== 1'b1 && n < 12) begin
         idle_step();
         n++;
      end
      if (valid_out !== 1'b1) chk({name, "_timeout"}, 32'(valid_out), 32'd1);
   endtask

   typedef struct {
      logic        en;
      logic        rdy;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pco;
      logic        valid;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [31:0] i0, i1, i2, i3;
      i0 = 32'h2001_0001; i1 = 32'h2002_0002; i2 = 32'h2003_0003; i3 = 32'h2004_0004;
      // en, rdy, rdata | expected req, addr, instr, pc_out, valid (outputs seen during that cycle)
      tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  NOP, 32'h0,  1'b0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  NOP, 32'h0,  1'b0};
      tbl[2]  = '{1'b0, 1'b1, i0,    1'b1, 32'h0,  NOP, 32'h0,  1'b0};
      tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  i0,  32'h4,  1'b1};
      tbl[4]  = '{1'b0, 1'b1, i1,    1'b1, 32'h4,  NOP, 32'h4,  1'b0};
      tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8,  i1,  32'h8,  1'b1};
      tbl[6]  = '{1'b1, 1'b1, i2,    1'b1, 32'h8,  NOP, 32'h8,  1'b0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'hC,  NOP, 32'h8,  1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'hC,  NOP, 32'h8,  1'b0};
      tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'hC,  NOP, 32'h8,  1'b0};
      tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC,  i2,  32'hC,  1'b1};
      tbl[11] = '{1'b0, 1'b1, i3,    1'b1, 32'hC,  NOP, 32'hC,  1'b0};
      tbl[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h10, i3,  32'h10, 1'b1};

      // Directed table: sequential fetch then a three-cycle stall into the hold buffer
      lat_mode = 1;
      do_reset();
      for (int r = 0; r < 13; r++) begin
         chk($sformatf("tbl%0d_req", r), 32'(imem_req), 32'(tbl[r].req));
         chk($sformatf("tbl%0d_addr", r), imem_addr, tbl[r].addr);
         chk($sformatf("tbl%0d_instr", r), Instruction_out, tbl[r].instr);
         chk($sformatf("tbl%0d_pcout", r), PC_out, tbl[r].pco);
         chk($sformatf("tbl%0d_valid", r), 32'(valid_out), 32'(tbl[r].valid));
         chk($sformatf("tbl%0d_flush", r), 32'(flush_out), 32'd0);
         enable = tbl[r].en; imem_ready = tbl[r].rdy; imem_rdata = tbl[r].rdata;
         @(posedge clk);
         @(negedge clk);
      end
      imem_ready = 1'b0;

      // Branch while a latency-3 request is outstanding
      lat_mode = 3;
      do_reset();
      idle_step();
      step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("a_flush", 32'(flush_out), 32'd1);
      chk("a_req_held", 32'(imem_req), 32'd1);
      chk("a_addr_held", imem_addr, 32'h0);
      idle_step();
      chk("a_flush_pulse", 32'(flush_out), 32'd0);
      for (int n = 0; n < 10 && imem_addr !== 32'h40; n++) idle_step();
      chk("a_next_addr", imem_addr, 32'h40);
      chk("a_next_req", 32'(imem_req), 32'd1);
      wait_valid("a_deliver");
      chk("a_instr", Instruction_out, mem_word(32'h40));
      chk("a_pcout", PC_out, 32'h44);

      // Branch beats jump; jump target low bits dropped
      lat_mode = 1;
      do_reset();
      step(1'b0, 1'b1, 32'h80, 1'b1, 32'h100);
      chk("b_prio_addr", imem_addr, 32'h80);
      chk("b_flush", 32'(flush_out), 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
      idle_step();
      chk("b_jump_addr", imem_addr, 32'h100);
      wait_valid("b_deliver");
      chk("b_instr", Instruction_out, mem_word(32'h100));
      chk("b_pcout", PC_out, 32'h104);

      // PC wrap at the top of the address space
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      chk("c_addr", imem_addr, 32'hFFFF_FFFC);
      wait_valid("c_deliver");
      chk("c_instr", Instruction_out, mem_word(32'hFFFF_FFFC));
      chk("c_pcout", PC_out, 32'h0);
      chk("c_next_addr", imem_addr, 32'h0);

      // Asynchronous reset in the middle of a drain
      lat_mode = 3;
      do_reset();
      idle_step();
      step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("d_in_drain", 32'(imem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_values("d_async");

      // Random traffic against the reference model
      lat_mode = -1;
      do_reset();
      deliveries = 0;
      for (int n = 0; n < 4000; n++) begin
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom,
              ($urandom_range(0, 19) == 0), $urandom);
      end
      chk("rand_progress", 32'(deliveries > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage of the 5-stage MIPS pipeline. Holds the PC and issues word fetches to instruction memory over a req/ready handshake. Delivers {instruction, PC+4} directly into the IF/ID pipeline register, absorbing hazard stalls with a one-entry hold buffer. Applies branch/jump redirects from ID, discarding in-flight or buffered wrong-path instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
NOP_WORD, 32'hE000_0000, bubble encoding (opcode 111000, control-unit default)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  hazard-unit stall; 1 = hold IF outputs, 0 = advance
branch_taken  in  1  ID-stage branch resolved taken this cycle
branch_target  in  32  branch destination
jump  in  1  ID-stage jump this cycle
jump_target  in  32  jump destination
imem_req  out  1  fetch request; held until imem_ready
imem_addr  out  32  fetch word address; stable while imem_req=1
imem_ready  in  1  one-cycle pulse, imem_rdata valid
imem_rdata  in  32  fetched instruction
Instruction_out  out  32  instruction to IF/ID register
PC_out  out  32  PC+4 of Instruction_out
valid_out  out  1  Instruction_out is a real instruction
flush_out  out  1  one-cycle pulse to IF/ID reset input on redirect

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, Instruction_out=NOP_WORD, PC_out=0, valid_out=0, flush_out=0, hold buffer empty.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr=PC. On imem_ready: if enable=0, Instruction_out<=imem_rdata, PC_out<=PC+4, valid_out<=1, PC<=PC+4, stay REQ (next request issued next cycle). If enable=1, capture {rdata, PC+4} in hold buffer, PC<=PC+4, -> HOLD.
- HOLD: imem_req=0; outputs frozen. When enable=0: buffer -> outputs, valid_out=1, -> REQ.
- Output registers never change while enable=1, except on redirect (bubble). Cycles with enable=0 and no instruction delivered: Instruction_out<=NOP_WORD, valid_out<=0, PC_out unchanged.
- Redirect: branch_taken has priority over jump; target low 2 bits forced to 0. Redirect overrides enable. Effect next edge: PC<=target, flush_out=1 for exactly one cycle, Instruction_out<=NOP_WORD, valid_out<=0, hold buffer cleared.
  - Redirect in REQ with request outstanding and imem_ready=0: -> DRAIN (req/addr held stable to honour handshake).
  - Redirect same cycle as imem_ready: returning data discarded, -> REQ at target.
  - Redirect in HOLD or IDLE: -> REQ at target.
- DRAIN: imem_req=1 on old address; on imem_ready data discarded, -> REQ. Second redirect while in DRAIN updates PC to newest target, flush_out pulses again.
- Arithmetic: PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Latency: imem_ready at edge N -> Instruction_out valid after edge N (zero-wait memory gives one instruction per 2 cycles: req, ready).

Optional Feature:
IFU_PERF_COUNTERS_EN: when defined, adds outputs fetch_count[31:0] (instructions delivered with valid_out=1) and stall_count[31:0] (cycles with enable=1), both reset to 0, wrap at 2^32. When undefined, ports and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset release, RESET_PC=0, imem_ready one cycle after each req, enable=0 -> imem_addr 0,4,8; Instruction_out matches rdata, PC_out 4,8,12, valid_out=1 on delivery cycles.
- enable=1 asserted as imem_ready returns word at PC=8 -> state HOLD, outputs frozen; enable=0 three cycles later -> that word appears with PC_out=12, next req addr=12.
- branch_taken, branch_target=32'h40, during outstanding req (memory latency 3) -> flush_out single pulse, imem_addr held until ready, data discarded, next req addr=32'h40.
- branch_taken and jump same cycle (targets 0x80, 0x100) -> PC=0x80; jump_target=0x103 alone -> fetch addr 0x100.
- PC=32'hFFFF_FFFC fetch -> PC_out=0, next req addr=0.
- reset asserted mid-DRAIN -> immediate return to reset values, imem_req=0 without waiting for clk.
